rvfi_liveness_window_check: RTL and testbench

- Parametrised successor of the single-step RVFI liveness checker.
- After a trigger instruction retires on a selected channel, it tracks the next DEPTH instructions in program order across all NRET retire channels.
- Flags failure if they have not all retired by a bounded cycle budget or by the external check strobe.
- Sits beside the core wrapper in formal and simulation harnesses. It exposes status outputs and an assertion on fail.

---
 rtl/rvfi_liveness_window_check.sv | 107 ++++++++++
 tb/tb_rvfi_liveness_window_check.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_liveness_window_check.sv
// Liveness window checker: once a trigger instruction retires, the next DEPTH
// instructions in program order must all retire before the timeout or the check strobe.
module rvfi_liveness_window_check #(
  parameter int NRET        = 1,
  parameter int CHANNEL_IDX = 0,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT     = 32,
  parameter int CNT_W       = 16
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 trig,
  input  logic                 check,
  input  logic [NRET-1:0]      rvfi_valid,
  input  logic [64*NRET-1:0]   rvfi_order,
  input  logic [NRET-1:0]      rvfi_halt,
  output logic                 armed,
  output logic                 done,
  output logic                 fail,
  output logic [DEPTH-1:0]     found_mask,
  output logic [63:0]          base_order,
  output logic [CNT_W-1:0]     timer
);

  typedef enum logic [1:0] {IDLE, ARMED, DONE, FAIL} state_t;

  localparam logic [CNT_W:0]   TIMEOUT_EXT = (CNT_W+1)'(TIMEOUT);
  localparam logic [CNT_W-1:0] TIMER_MAX   = '1;

  state_t           state;
  logic [63:0]      arm_order;
  logic [63:0]      ref_order;
  logic             arm_req;
  logic [DEPTH-1:0] hits;
  logic [DEPTH-1:0] next_mask;
  logic [CNT_W:0]   timer_inc;
  logic             timeout_hit;

  assign arm_order = rvfi_order[64*CHANNEL_IDX +: 64];
  assign arm_req   = trig && rvfi_valid[CHANNEL_IDX] && !rvfi_halt[CHANNEL_IDX];

  // While arming, the window is anchored on the trigger's own order so that
  // same-cycle successors on other channels are captured immediately.
  assign ref_order = (state == ARMED) ? base_order : arm_order;

  always_comb begin
    hits = '0;
    for (int c = 0; c < NRET; c++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (rvfi_valid[c] && (rvfi_order[64*c +: 64] == ref_order + 64'(k + 1))) begin
          hits[k] = 1'b1;
        end
      end
    end
  end

  assign next_mask   = found_mask | hits;
  assign timer_inc   = {1'b0, timer} + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (timer_inc >= TIMEOUT_EXT);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= IDLE;
      found_mask <= '0;
      base_order <= '0;
      timer      <= '0;
      armed      <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arm_req) begin
            state      <= ARMED;
            armed      <= 1'b1;
            base_order <= arm_order;
            timer      <= '0;
            found_mask <= hits;
          end
        end
        ARMED: begin
          found_mask <= next_mask;
          timer      <= (timer == TIMER_MAX) ? timer : timer + 1'b1;
          // Completion wins over a simultaneous timeout or check strobe.
          if (&next_mask) begin
            state <= DONE;
            armed <= 1'b0;
            done  <= 1'b1;
          end else if (timeout_hit || check) begin
            state <= FAIL;
            armed <= 1'b0;
            fail  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef RISCV_FORMAL
  always @(posedge clock) begin
    if (resetn) assert (!fail);
  end
`endif

endmodule

// File: tb/tb_rvfi_liveness_window_check.sv
// Bench for rvfi_liveness_window_check: directed scenarios then random traffic,
// every cycle compared against a window model built from order differences.
module tb_rvfi_liveness_window_check;

  localparam int NRET    = 2;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 12;
  localparam int CNT_W   = 8;

  logic               clock = 1'b0;
  logic               resetn;
  logic               trig;
  logic               check;
  logic [NRET-1:0]    rvfi_valid;
  logic [64*NRET-1:0] rvfi_order;
  logic [NRET-1:0]    rvfi_halt;
  logic               armed;
  logic               done;
  logic               fail;
  logic [DEPTH-1:0]   found_mask;
  logic [63:0]        base_order;
  logic [CNT_W-1:0]   timer;

  int nChecks = 0;
  int nErrors = 0;

  // Model: mode 0 idle, 1 armed, 2 done, 3 fail
  int               mMode  = 0;
  logic [63:0]      mBase  = '0;
  logic [DEPTH-1:0] mFound = '0;
  int               mTimer = 0;

  rvfi_liveness_window_check #(
    .NRET(NRET), .CHANNEL_IDX(0), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .resetn(resetn), .trig(trig), .check(check),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_halt(rvfi_halt),
    .armed(armed), .done(done), .fail(fail), .found_mask(found_mask),
    .base_order(base_order), .timer(timer)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // An order belongs to the window when (order - base - 1) mod 2^64 < DEPTH.
  task automatic markOrders(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1);
    logic [63:0] d;
    for (int c = 0; c < NRET; c++) begin
      if (v[c]) begin
        d = ((c == 0) ? o0 : o1) - mBase - 64'd1;
        if (d < 64'(DEPTH)) mFound[int'(d)] = 1'b1;
      end
    end
  endtask

  task automatic modelStep(input logic rn, input logic tg, input logic ck,
                           input logic [1:0] v, input logic [63:0] o0,
                           input logic [63:0] o1, input logic [1:0] h);
    if (!rn) begin
      mMode = 0; mBase = '0; mFound = '0; mTimer = 0;
    end else if (mMode == 0) begin
      if (tg && v[0] && !h[0]) begin
        mBase = o0; mFound = '0; mTimer = 0;
        markOrders(v, o0, o1);
        mMode = 1;
      end
    end else if (mMode == 1) begin
      markOrders(v, o0, o1);
      if ($countones(mFound) == DEPTH) mMode = 2;
      else if (mTimer + 1 >= TIMEOUT || ck) mMode = 3;
      if (mTimer < (1 << CNT_W) - 1) mTimer++;
    end
  endtask

  task automatic compareAll();
    checkOutput("armed", 64'(armed), 64'(mMode == 1));
    checkOutput("done", 64'(done), 64'(mMode == 2));
    checkOutput("fail", 64'(fail), 64'(mMode == 3));
    checkOutput("found_mask", 64'(found_mask), 64'(mFound));
    checkOutput("base_order", base_order, mBase);
    if (mMode <= 1) checkOutput("timer", 64'(timer), 64'(mTimer));
  endtask

  task automatic applyStimulus(input logic rn, input logic tg, input logic ck,
                               input logic [1:0] v, input logic [63:0] o0,
                               input logic [63:0] o1, input logic [1:0] h);
    resetn     = rn;
    trig       = tg;
    check      = ck;
    rvfi_valid = v;
    rvfi_order = {o1, o0};
    rvfi_halt  = h;
    modelStep(rn, tg, ck, v, o0, o1, h);
    @(posedge clock);
    #1;
    compareAll();
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 64'd0, 64'd0, 2'b00);
  endtask

  initial begin
    logic        rn, tg, ck;
    logic [1:0]  v, h;
    logic [63:0] o0, o1;

    doReset();
    doReset();
    checkOutput("rst_armed", 64'(armed), 64'd0);
    checkOutput("rst_mask", 64'(found_mask), 64'd0);

    // Single-channel consecutive successors
    applyStimulus(1, 1, 0, 2'b01, 64'd10, 64'd0, 2'b00);
    for (int i = 11; i <= 14; i++) begin
      applyStimulus(1, 0, 0, 2'b01, 64'(i), 64'd0, 2'b00);
      if (i == 13) checkOutput("seq_mask", 64'(found_mask), 64'b0111);
    end
    checkOutput("seq_done", 64'(done), 64'd1);

    // Successor retiring alongside the trigger
    doReset();
    applyStimulus(1, 1, 0, 2'b11, 64'd100, 64'd101, 2'b00);
    checkOutput("pair_mask", 64'(found_mask), 64'b0001);
    applyStimulus(1, 0, 0, 2'b11, 64'd102, 64'd103, 2'b00);
    checkOutput("pair_mask2", 64'(found_mask), 64'b0111);
    applyStimulus(1, 0, 0, 2'b01, 64'd104, 64'd0, 2'b00);
    checkOutput("pair_done", 64'(done), 64'd1);

    // Timeout with two successors missing
    doReset();
    applyStimulus(1, 1, 0, 2'b01, 64'd5, 64'd0, 2'b00);
    applyStimulus(1, 0, 0, 2'b01, 64'd6, 64'd0, 2'b00);
    applyStimulus(1, 0, 0, 2'b01, 64'd7, 64'd0, 2'b00);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1, 0, 0, 2'b00, 64'd0, 64'd0, 2'b00);
      if (i == 9) checkOutput("to_not_yet", 64'(fail), 64'd0);
    end
    checkOutput("to_fail", 64'(fail), 64'd1);
    checkOutput("to_mask", 64'(found_mask), 64'b0011);

    // Check strobe before completion, then completion on the check cycle
    doReset();
    applyStimulus(1, 1, 0, 2'b01, 64'd20, 64'd0, 2'b00);
    applyStimulus(1, 0, 0, 2'b01, 64'd21, 64'd0, 2'b00);
    applyStimulus(1, 0, 1, 2'b00, 64'd0, 64'd0, 2'b00);
    checkOutput("chk_fail", 64'(fail), 64'd1);
    doReset();
    applyStimulus(1, 1, 0, 2'b01, 64'd20, 64'd0, 2'b00);
    applyStimulus(1, 0, 0, 2'b11, 64'd21, 64'd22, 2'b00);
    applyStimulus(1, 0, 0, 2'b01, 64'd23, 64'd0, 2'b00);
    applyStimulus(1, 0, 1, 2'b01, 64'd24, 64'd0, 2'b00);
    checkOutput("chk_done", 64'(done), 64'd1);
    checkOutput("chk_nofail", 64'(fail), 64'd0);

    // Wrap-around past 2^64-1; the trigger's own order sets no bit
    doReset();
    applyStimulus(1, 1, 0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 2'b00);
    applyStimulus(1, 0, 0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 2'b00);
    checkOutput("wrap_mask", 64'(found_mask), 64'b0001);
    applyStimulus(1, 0, 0, 2'b11, 64'd0, 64'd1, 2'b00);
    applyStimulus(1, 0, 0, 2'b01, 64'd2, 64'd0, 2'b00);
    checkOutput("wrap_done", 64'(done), 64'd1);

    // Reset while armed discards tracking; re-arm with a new base
    doReset();
    applyStimulus(1, 1, 0, 2'b01, 64'd30, 64'd0, 2'b00);
    applyStimulus(1, 0, 0, 2'b11, 64'd31, 64'd33, 2'b00);
    checkOutput("mid_mask", 64'(found_mask), 64'b0101);
    doReset();
    checkOutput("mid_rst_mask", 64'(found_mask), 64'd0);
    applyStimulus(1, 1, 0, 2'b01, 64'd50, 64'd0, 2'b00);
    checkOutput("rearm_base", base_order, 64'd50);

    // Random traffic clustered around the current window
    for (int n = 0; n < 3000; n++) begin
      rn = ($urandom_range(0, 39) != 0) && !(mMode >= 2 && $urandom_range(0, 3) == 0);
      tg = 1'($urandom_range(0, 1));
      ck = ($urandom_range(0, 15) == 0);
      v  = 2'($urandom_range(0, 3));
      h  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      if (mMode == 0) begin
        case ($urandom_range(0, 3))
          0:       o0 = {$urandom, $urandom};
          1:       o0 = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 5));
          default: o0 = 64'($urandom_range(0, 1000));
        endcase
        o1 = o0 + 64'($urandom_range(0, DEPTH + 1));
      end else begin
        o0 = mBase + 64'($urandom_range(0, DEPTH + 2));
        o1 = mBase + 64'($urandom_range(0, DEPTH + 2));
      end
      applyStimulus(rn, tg, ck, v, o0, o1, h);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
